// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART transmitter definitions: state encodings, LCR bit positions,
// FIFO sizing defaults and the parity helper.
package uart_tx_serializer_pkg;

    localparam int UART_FIFO_WIDTH     = 8;
    localparam int UART_FIFO_COUNTER_W = 5;

    // LCR bit positions; [1:0] is the word-length select
    localparam int LCR_STB = 2;
    localparam int LCR_PEN = 3;
    localparam int LCR_EPS = 4;
    localparam int LCR_SP  = 5;
    localparam int LCR_BC  = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Stick parity overrides even/odd selection and sends the inverse of EPS
    function automatic logic parity_bit(input logic eps, input logic sp, input logic data_xor);
        if (sp)
            return ~eps;
        return eps ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops words from the TX FIFO and shifts them out
// as start/data/parity/stop frames, one bit per 16 enable pulses.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int fifo_width     = UART_FIFO_WIDTH,
    parameter int fifo_counter_w = UART_FIFO_COUNTER_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [7:0]                lcr,
    input  logic [fifo_counter_w-1:0] tf_count,
    input  logic [fifo_width-1:0]     tf_data_out,
    output logic                      tf_pop,
    output logic                      stx_pad_o,
    output logic [2:0]                tstate,
    output logic                      tx_busy
);

    tx_state_e             state_reg, state_next;
    logic [3:0]            tick_reg, tick_next;
    logic [2:0]            bit_cnt_reg, bit_cnt_next;
    logic [fifo_width-1:0] shift_reg, shift_next;
    logic [5:0]            lcr_reg, lcr_next;
    logic                  par_xor_reg, par_xor_next;
    logic                  stx_reg, stx_next;
    logic                  load;
    logic                  last_data_bit;
    logic                  stop_done;
    logic                  word_xor;
    logic [fifo_width-1:0] data_mask;
    logic                  lcr_unused;

    assign lcr_unused = lcr[7];

    // Parity is taken over the bits that will actually be sent
    for (genvar gi = 0; gi < fifo_width; gi++) begin : g_mask
        assign data_mask[gi] = (gi < (int'(lcr[1:0]) + 5));
    end
    assign word_xor = ^(tf_data_out & data_mask);

    assign last_data_bit = (bit_cnt_reg == (3'd4 + {1'b0, lcr_reg[1:0]}));

    // Extra stop is 1.5 bit periods for 5-bit words, two otherwise
    always_comb begin
        stop_done = 1'b0;
        if (!lcr_reg[LCR_STB])
            stop_done = (tick_reg == 4'd15);
        else if (lcr_reg[1:0] == 2'd0)
            stop_done = (bit_cnt_reg == 3'd1) && (tick_reg == 4'd7);
        else
            stop_done = (bit_cnt_reg == 3'd1) && (tick_reg == 4'd15);
    end

    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        lcr_next     = lcr_reg;
        par_xor_next = par_xor_reg;
        load         = 1'b0;

        if (enable) begin
            tick_next = tick_reg + 4'd1;
            case (state_reg)
                ST_IDLE: begin
                    tick_next = 4'd0;
                    load      = (tf_count != '0);
                end
                ST_START: begin
                    if (tick_reg == 4'd15)
                        state_next = ST_DATA;
                end
                ST_DATA: begin
                    if (tick_reg == 4'd15) begin
                        shift_next = shift_reg >> 1;
                        if (last_data_bit) begin
                            bit_cnt_next = 3'd0;
                            state_next   = lcr_reg[LCR_PEN] ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick_reg == 4'd15)
                        state_next = ST_STOP;
                end
                ST_STOP: begin
                    if (tick_reg == 4'd15)
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (stop_done) begin
                        tick_next    = 4'd0;
                        bit_cnt_next = 3'd0;
                        state_next   = ST_IDLE;
                        load         = (tf_count != '0);
                    end
                end
                default: state_next = ST_IDLE;
            endcase

            if (load) begin
                state_next   = ST_START;
                tick_next    = 4'd0;
                bit_cnt_next = 3'd0;
                shift_next   = tf_data_out;
                lcr_next     = lcr[5:0];
                par_xor_next = word_xor;
            end
        end
    end

    // Line level is derived from the post-edge state so it lands on the same edge
    always_comb begin
        stx_next = 1'b1;
        case (state_next)
            ST_START:  stx_next = 1'b0;
            ST_DATA:   stx_next = shift_next[0];
            ST_PARITY: stx_next = parity_bit(lcr_next[LCR_EPS], lcr_next[LCR_SP], par_xor_next);
            default:   stx_next = 1'b1;
        endcase
        if (lcr[LCR_BC])
            stx_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            tick_reg    <= 4'd0;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= '0;
            lcr_reg     <= 6'd0;
            par_xor_reg <= 1'b0;
            stx_reg     <= 1'b1;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            lcr_reg     <= lcr_next;
            par_xor_reg <= par_xor_next;
            stx_reg     <= stx_next;
        end
    end

    assign tf_pop    = load & rst_n;
    assign stx_pad_o = stx_reg;
    assign tstate    = state_reg;
    assign tx_busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: each queued word pushes its full
// expected line waveform (one sample per enable pulse) for comparison.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] lcr = 8'h03;
    logic [4:0] tf_count = 5'd0;
    logic [7:0] tf_data_out = 8'h00;
    logic       tf_pop;
    logic       stx_pad_o;
    logic [2:0] tstate;
    logic       tx_busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] fifo_q[$];
    logic       exp_q[$];
    int         len_q[$];
    int         armed = 0;

    uart_tx_serializer #(
        .fifo_width     (8),
        .fifo_counter_w (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .lcr         (lcr),
        .tf_count    (tf_count),
        .tf_data_out (tf_data_out),
        .tf_pop      (tf_pop),
        .stx_pad_o   (stx_pad_o),
        .tstate      (tstate),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic fifo_sync();
        tf_count    = 5'(fifo_q.size());
        tf_data_out = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    // Builds the expected frame from the lcr value live when the word is queued
    task automatic send(input logic [7:0] w);
        int   nb;
        int   stop_len;
        logic x;
        logic p;
        nb = 5 + int'(lcr[1:0]);
        x  = 1'b0;
        for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
        for (int b = 0; b < nb; b++) begin
            x = x ^ w[b];
            for (int i = 0; i < 16; i++) exp_q.push_back(w[b]);
        end
        if (lcr[3]) begin
            p = lcr[5] ? ~lcr[4] : (lcr[4] ? x : ~x);
            for (int i = 0; i < 16; i++) exp_q.push_back(p);
        end
        stop_len = !lcr[2] ? 16 : ((nb == 5) ? 24 : 32);
        for (int i = 0; i < stop_len; i++) exp_q.push_back(1'b1);
        len_q.push_back(16 * (1 + nb + int'(lcr[3])) + stop_len);
        fifo_q.push_back(w);
        fifo_sync();
        $display("queue word %02h lcr %02h frame %0d enables", w, lcr, len_q[len_q.size()-1]);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(armed == 0 && fifo_q.size() == 0 && len_q.size() == 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(n < 4000), 1);
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_armed(input int thr);
        int n;
        n = 0;
        while (!(armed > 0 && armed <= thr) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("armed_timeout", 32'(n < 4000), 1);
    endtask

    // One enable pulse every fourth clock
    initial begin
        int ecnt;
        ecnt = 0;
        forever begin
            @(negedge clk);
            ecnt++;
            enable = (ecnt % 4 == 0);
        end
    end

    // Inputs are sampled just before the edge, outputs 1 time unit after it
    initial begin
        logic en_s, pop_s, brk_s, rst_s, e;
        logic [4:0] cnt_s;
        forever begin
            @(negedge clk);
            #4;
            en_s  = enable;
            pop_s = tf_pop;
            cnt_s = tf_count;
            brk_s = lcr[6];
            rst_s = rst_n;
            @(posedge clk);
            #1;
            if (!rst_s) begin
                check("rst_stx", 32'(stx_pad_o), 1);
                check("rst_state", 32'(tstate), 0);
                check("rst_busy", 32'(tx_busy), 0);
                check("rst_pop", 32'(pop_s), 0);
                while (armed > 0) begin
                    void'(exp_q.pop_front());
                    armed--;
                end
            end else begin
                if (pop_s) begin
                    check("pop_empty", 32'(cnt_s != 0), 1);
                    check("pop_gap", 32'(armed), 0);
                    check("pop_extra", 32'(len_q.size() > 0), 1);
                    check("start_state", 32'(tstate), 1);
                    $display("pop word %02h at %0t", (fifo_q.size() > 0) ? fifo_q[0] : 8'h00, $time);
                    if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                    fifo_sync();
                    if (len_q.size() > 0) armed = len_q.pop_front();
                end
                if (brk_s)
                    check("break", 32'(stx_pad_o), 0);
                if (en_s) begin
                    if (armed > 0) begin
                        e = exp_q.pop_front();
                        armed--;
                        check("busy", 32'(tx_busy), 1);
                        if (!brk_s)
                            check("line", 32'(stx_pad_o), 32'(e));
                    end else begin
                        check("idle_state", 32'(tstate), 0);
                        check("idle_busy", 32'(tx_busy), 0);
                        if (!brk_s)
                            check("idle_line", 32'(stx_pad_o), 1);
                    end
                end
            end
        end
    end

    initial begin
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        lcr = 8'h03;
        send(8'h55);
        wait_done();

        lcr = 8'h1B;
        send(8'h07);
        wait_done();

        // Mid-frame lcr change must not disturb the latched frame format
        lcr = 8'h04;
        send(8'h1F);
        wait_armed(100);
        @(negedge clk);
        lcr = 8'h1B;
        wait_done();

        lcr = 8'h03;
        send(8'hA5);
        send(8'h3C);
        wait_done();

        // Reset during data bit 3 of the first of three queued words
        send(8'h12);
        send(8'h34);
        send(8'h56);
        wait_armed(160 - (16 + 48 + 5));
        @(negedge clk);
        rst_n = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_count", 32'(tf_count), 2);
        rst_n = 1'b1;
        wait_done();

        // Break asserted for part of a frame
        send(8'hC3);
        wait_armed(100);
        @(negedge clk);
        lcr = 8'h43;
        repeat (20) @(negedge clk);
        lcr = 8'h03;
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter fifo_width, default `UART_FIFO_WIDTH (8), the transmit data word width.
REQ-002 SHALL have parameter fifo_counter_w, default `UART_FIFO_COUNTER_W (5), the width of the TX FIFO occupancy count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register in the block is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: a one-clk pulse at 16x the baud rate.
REQ-006 SHALL have port lcr, input, 8 bits: line control.
- [1:0]: word length, 5+value data bits.
- [2]: extra stop.
- [3]: parity enable.
- [4]: even parity.
- [5]: stick parity.
- [6]: break.
- [7]: ignored.
REQ-007 SHALL have port tf_count, input, fifo_counter_w bits: the occupancy of the upstream TX FIFO.
REQ-008 SHALL have port tf_data_out, input, fifo_width bits: the FIFO head word, valid whenever tf_count is nonzero.
REQ-009 SHALL have port tf_pop, output, 1 bit: a one-clk pop strobe to the FIFO.
REQ-010 SHALL have port stx_pad_o, output, 1 bit: the serial line output, idle high.
REQ-011 SHALL have port tstate, output, 3 bits: the current state encoding.
REQ-012 SHALL have port tx_busy, output, 1 bit: high whenever tstate is not IDLE.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY and STOP.
- The encodings are 0 through 4, in that order.
REQ-014 SHALL leave state and all counters unchanged in any cycle without enable; all sequencing advances only on enable cycles.
REQ-015 SHALL make every bit period last exactly 16 enable pulses, counted by a 4-bit tick counter.
REQ-016 SHALL, in IDLE with enable high and tf_count nonzero, do all of the following in that same cycle, then enter START:
- capture tf_data_out into the shift register;
- capture lcr into a frame-local copy;
- assert tf_pop for exactly one clk.
REQ-017 SHALL drive stx_pad_o as follows in each state:
- START: 0.
- DATA: the shift register LSB, bits sent LSB-first, shifting once per bit period, for 5+lcr[1:0] bits.
- PARITY: the parity bit (REQ-019).
- STOP: 1.
REQ-018 SHALL enter PARITY after DATA only when the latched lcr[3] is 1; otherwise SHALL go from DATA directly to STOP.
REQ-019 SHALL compute the parity bit over the sent data bits only, as follows:
- lcr[5]=0 and lcr[4]=1: XOR of the data bits.
- lcr[5]=0 and lcr[4]=0: the inverse of that XOR.
- lcr[5]=1: the inverse of lcr[4].
REQ-020 SHALL make STOP last the following number of enable pulses:
- lcr[2]=0: 16.
- lcr[2]=1 with a 5-bit word: 24.
- lcr[2]=1 with any other word length: 32.
REQ-021 SHALL, on the final enable pulse of STOP, start the next frame back-to-back if tf_count is nonzero: perform the REQ-016 actions and go to START with no idle gap. Otherwise it SHALL go to IDLE.
REQ-022 SHALL use the lcr copy latched at frame start for the whole frame; lcr changes mid-frame take effect at the next frame only.
REQ-023 SHALL, while the live lcr[6] is 1, force stx_pad_o to 0 in every state, with the state machine continuing unaffected.
REQ-024 SHALL never assert tf_pop when tf_count is 0.
REQ-025 SHALL assert tf_pop at most once per frame.
REQ-026 SHALL register stx_pad_o, with no combinational path from inputs to stx_pad_o.

Reset
REQ-027 SHALL, on the clk edge where rst_n is 0, set state to IDLE, tick and bit counters to 0, and the shift register to 0.
REQ-028 SHALL hold the following output values during and after reset: stx_pad_o=1, tf_pop=0, tx_busy=0, tstate=0.
REQ-029 SHALL abort any frame in progress when reset occurs mid-frame: stx_pad_o returns to 1 on the next edge and no further pop is issued.

Structure
REQ-030 SHALL take the following from the shared uart_defines.v: the state encodings, the LCR bit indices, UART_FIFO_WIDTH and UART_FIFO_COUNTER_W.
REQ-031 SHALL be a single module with no sub-module; parity and timing logic stay inline.

Verification
REQ-032 SHALL cover word 0x55 with lcr=0x03 and tf_count=1.
- One tf_pop.
- Line pattern: 0, then 1,0,1,0,1,0,1,0, then 1, each bit 16 enables.
- Returns to IDLE.
REQ-033 SHALL cover word 0x07 with lcr=0x1B (8 bits, even parity): parity bit 1 and a total frame of 11x16 enables.
REQ-034 SHALL cover lcr=0x04 (5 bits, extra stop) with word 0x1F: STOP lasts 24 enables.
REQ-035 SHALL cover tf_count=2 with words 0xA5 and 0x3C.
- Second tf_pop on the last STOP enable.
- Second start bit begins on the next enable with no gap.
REQ-036 SHALL cover rst_n=0 during DATA bit 3.
- Next edge: stx_pad_o=1, tstate=0, tx_busy=0.
- No tf_pop while tf_count stays 2.
REQ-037 SHALL cover asserting lcr[6] mid-frame: stx_pad_o=0 immediately on the registered edge, with the frame timing unchanged.
